// File: rtl/spike_event_encoder_if.sv
// Queue-side port bundle between the spike encoder (producer) and the 8-bit event queue.
// Handshake: each cycle insert_o=1 delivers exactly one data_o entry; full_i is an early
// "no room" flag raised while one slot is still free, so one in-flight insert is always safe.
interface spike_event_encoder_if #(
  parameter int IDX_W = 8
) ();
  logic             insert_o;
  logic [IDX_W-1:0] data_o;
  logic             full_i;

  modport master (output insert_o, output data_o, input full_i);
  modport slave  (input insert_o, input data_o, output full_i);
endinterface

// File: rtl/spike_event_encoder.sv
// Captures a per-neuron fire vector on start and streams the set indices lowest-first
// into the event queue, stalling on full, then pulses done with the event count.
module spike_event_encoder #(
  parameter int N     = 256,
  parameter int IDX_W = 8,
  parameter int CNT_W = 9
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [N-1:0]         spikes_i,
  spike_event_encoder_if.master q,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [CNT_W-1:0]     count_o,
  output logic [1:0]           state_dbg_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [N-1:0]     mask_q, mask_d;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] data_d;
  logic             ins_d;
  logic [CNT_W-1:0] cnt_d;

  assign state_dbg_o = state_q;

  // Lowest set bit wins: scan from the top so the last hit is the smallest index.
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (mask_q[i]) idx = IDX_W'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    ins_d   = 1'b0;
    data_d  = q.data_o;
    cnt_d   = count_o;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          mask_d  = spikes_i;
          cnt_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (mask_q == '0) begin
          state_d = DONE;
        end else if (!q.full_i) begin
          ins_d  = 1'b1;
          data_d = idx;
          // Clearing the lowest set bit retires exactly the index just emitted.
          mask_d = mask_q & (mask_q - N'(1));
          cnt_d  = count_o + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // busy_o/done_o are registered from the state, so they trail it by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      mask_q     <= '0;
      q.insert_o <= 1'b0;
      q.data_o   <= '0;
      count_o    <= '0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      q.insert_o <= ins_d;
      q.data_o   <= data_d;
      count_o    <= cnt_d;
      busy_o     <= (state_q != IDLE);
      done_o     <= (state_q == DONE);
    end
  end

endmodule

// File: tb/tb_spike_event_encoder.sv
// Bench for spike_event_encoder: table of scan scenarios plus randomized vectors,
// checked cycle by cycle against a queue-based model of the index stream.
module tb_spike_event_encoder;
  localparam int N     = 256;
  localparam int IDX_W = 8;
  localparam int CNT_W = 9;

  logic             clk = 1'b0;
  logic             rst;
  logic             start_i;
  logic [N-1:0]     spikes_i;
  logic             busy_o;
  logic             done_o;
  logic [CNT_W-1:0] count_o;
  logic [1:0]       state_dbg;

  spike_event_encoder_if #(.IDX_W(IDX_W)) q_if ();

  spike_event_encoder #(.N(N), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .spikes_i    (spikes_i),
    .q           (q_if),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .count_o     (count_o),
    .state_dbg_o (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [IDX_W-1:0] exp_q[$];
  logic [IDX_W-1:0] last_data;

  typedef struct {
    logic [N-1:0] spikes;
    int           full_mode;   // 0: never full, 1: random full, 2: scripted stall
    int           stall_after; // stall begins once this many events were emitted
    int           stall_len;
    bit           mid_start;   // pulse start_i in the middle of the scan
    int           exp_count;
    int           exp_first;   // -1 when nothing is emitted
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] rand_vec();
    logic [N-1:0] v;
    for (int i = 0; i < N / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Drives one complete scan; the model is the ascending list of set indices, popped
  // once per cycle in which the queue had room.
  task automatic run_scan(input vec_t v, output int got_count, output int got_first);
    int emitted;
    int stall_used;
    int end_cyc;
    bit f;
    bit e_ins;
    bit e_busy;
    bit e_done;
    bit done_seen;
    emitted    = 0;
    stall_used = 0;
    end_cyc    = -1;
    done_seen  = 1'b0;
    got_first  = -1;
    exp_q.delete();
    for (int i = 0; i < N; i++) if (v.spikes[i]) exp_q.push_back(IDX_W'(i));

    @(negedge clk);
    start_i  = 1'b1;
    spikes_i = v.spikes;
    q_if.full_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("start_insert", 32'(q_if.insert_o), 0);
    chk("start_busy", 32'(busy_o), 0);
    chk("start_count", 32'(count_o), 0);
    chk("start_done", 32'(done_o), 0);

    for (int cyc = 1; cyc <= 3 * N + 20; cyc++) begin
      case (v.full_mode)
        0:       f = 1'b0;
        1:       f = ($urandom_range(0, 3) == 0);
        default: f = (emitted == v.stall_after) && (stall_used < v.stall_len);
      endcase
      if (v.full_mode == 2 && f) stall_used++;
      q_if.full_i = f;
      start_i  = v.mid_start && (cyc == 50);
      spikes_i = rand_vec();

      e_ins = 1'b0;
      if (end_cyc < 0) begin
        if (exp_q.size() > 0) begin
          if (!f) begin
            e_ins     = 1'b1;
            last_data = exp_q.pop_front();
            emitted++;
          end
        end else begin
          end_cyc = cyc;
        end
      end
      e_busy = (end_cyc < 0) || (cyc <= end_cyc + 1);
      e_done = (end_cyc >= 0) && (cyc == end_cyc + 1);

      @(posedge clk);
      @(negedge clk);
      chk("insert", 32'(q_if.insert_o), 32'(e_ins));
      chk("data", 32'(q_if.data_o), 32'(last_data));
      chk("count", 32'(count_o), 32'(emitted));
      chk("busy", 32'(busy_o), 32'(e_busy));
      chk("done", 32'(done_o), 32'(e_done));
      if (q_if.insert_o === 1'b1 && got_first < 0) got_first = int'(q_if.data_o);
      if (e_done) begin
        done_seen = 1'b1;
        break;
      end
    end
    if (!done_seen) chk("scan_timeout", 0, 1);

    q_if.full_i = 1'b0;
    start_i     = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("idle_busy", 32'(busy_o), 0);
    chk("idle_done", 32'(done_o), 0);
    chk("idle_insert", 32'(q_if.insert_o), 0);
    chk("idle_count_hold", 32'(count_o), 32'(emitted));
    got_count = int'(count_o);
  endtask

  initial begin
    int gc;
    int gf;
    vec_t rv;
    logic [N-1:0] tmp;

    tbl[0] = '{spikes: '0, full_mode: 0, stall_after: 0, stall_len: 0, mid_start: 1'b0,
               exp_count: 1, exp_first: 5};
    tbl[0].spikes[5] = 1'b1;
    tbl[1] = '{spikes: '0, full_mode: 0, stall_after: 0, stall_len: 0, mid_start: 1'b0,
               exp_count: 3, exp_first: 0};
    tbl[1].spikes[0]   = 1'b1;
    tbl[1].spikes[3]   = 1'b1;
    tbl[1].spikes[255] = 1'b1;
    tbl[2] = '{spikes: '0, full_mode: 0, stall_after: 0, stall_len: 0, mid_start: 1'b0,
               exp_count: 0, exp_first: -1};
    tbl[3] = '{spikes: '0, full_mode: 2, stall_after: 2, stall_len: 3, mid_start: 1'b0,
               exp_count: 4, exp_first: 1};
    tbl[3].spikes[1] = 1'b1;
    tbl[3].spikes[2] = 1'b1;
    tbl[3].spikes[7] = 1'b1;
    tbl[3].spikes[9] = 1'b1;
    tbl[4] = '{spikes: '1, full_mode: 0, stall_after: 0, stall_len: 0, mid_start: 1'b1,
               exp_count: 256, exp_first: 0};

    rst         = 1'b1;
    start_i     = 1'b0;
    spikes_i    = '0;
    q_if.full_i = 1'b0;
    last_data   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_insert", 32'(q_if.insert_o), 0);
    chk("rst_data", 32'(q_if.data_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_done", 32'(done_o), 0);
    chk("rst_count", 32'(count_o), 0);
    chk("rst_state", 32'(state_dbg), 0);
    rst = 1'b0;

    foreach (tbl[i]) begin
      run_scan(tbl[i], gc, gf);
      chk("tbl_count", gc, tbl[i].exp_count);
      chk("tbl_first", gf, tbl[i].exp_first);
    end

    // reset in the middle of a scan, after two inserts
    tmp = '0;
    tmp[1] = 1'b1;
    tmp[4] = 1'b1;
    tmp[6] = 1'b1;
    @(negedge clk);
    start_i  = 1'b1;
    spikes_i = tmp;
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("mid_insert", 32'(q_if.insert_o), 1);
    chk("mid_data", 32'(q_if.data_o), 4);
    chk("mid_count", 32'(count_o), 2);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_insert", 32'(q_if.insert_o), 0);
    chk("mrst_busy", 32'(busy_o), 0);
    chk("mrst_count", 32'(count_o), 0);
    chk("mrst_data", 32'(q_if.data_o), 0);
    chk("mrst_state", 32'(state_dbg), 0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("mrst_no_done", 32'(done_o), 0);
      chk("mrst_no_insert", 32'(q_if.insert_o), 0);
    end
    last_data = '0;
    rv = '{spikes: '0, full_mode: 1, stall_after: 0, stall_len: 0, mid_start: 1'b0,
           exp_count: 2, exp_first: 3};
    rv.spikes[3] = 1'b1;
    rv.spikes[8] = 1'b1;
    run_scan(rv, gc, gf);
    chk("post_rst_count", gc, 2);
    chk("post_rst_first", gf, 3);

    // randomized vectors of varying density with random backpressure
    for (int r = 0; r < 6; r++) begin
      rv.spikes = rand_vec();
      if (r % 2 == 0) rv.spikes &= rand_vec() & rand_vec();
      rv.full_mode = 1;
      rv.mid_start = 1'b0;
      run_scan(rv, gc, gf);
      chk("rand_count", gc, $countones(rv.spikes));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
